// File: rtl/bus_demux1_2_reg.sv
// Registered 1-to-2 bus demultiplexer with valid/ready handshaking.
// Each output owns a one-entry register; a stall on one port only blocks words aimed at that port.
module bus_demux1_2_reg #(
    parameter int WIDTH     = 64,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     out0_data,
    output logic                 out0_valid,
    input  logic                 out0_ready,
    output logic [WIDTH-1:0]     out1_data,
    output logic                 out1_valid,
    input  logic                 out1_ready,
    output logic [CNT_WIDTH-1:0] count0,
    output logic [CNT_WIDTH-1:0] count1
);

    localparam logic [CNT_WIDTH-1:0] CntOne = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CntMax = {CNT_WIDTH{1'b1}};

    logic [WIDTH-1:0]     data0_q, data0_d;
    logic [WIDTH-1:0]     data1_q, data1_d;
    logic                 valid0_q, valid0_d;
    logic                 valid1_q, valid1_d;
    logic [CNT_WIDTH-1:0] cnt0_q, cnt0_d;
    logic [CNT_WIDTH-1:0] cnt1_q, cnt1_d;

    logic space0, space1;
    logic load0, load1;
    logic drain0, drain1;

    // A port has room when it is empty or its word leaves on this same edge.
    assign space0   = ~valid0_q | out0_ready;
    assign space1   = ~valid1_q | out1_ready;
    assign in_ready = in_sel ? space1 : space0;

    assign load0  = in_valid & in_ready & ~in_sel;
    assign load1  = in_valid & in_ready &  in_sel;
    assign drain0 = valid0_q & out0_ready;
    assign drain1 = valid1_q & out1_ready;

    always_comb begin
        data0_d  = data0_q;
        valid0_d = valid0_q;
        cnt0_d   = cnt0_q;
        if (load0) begin
            data0_d  = in_data;
            valid0_d = 1'b1;
            if (cnt0_q != CntMax) begin
                cnt0_d = cnt0_q + CntOne;
            end
        end else if (drain0) begin
            valid0_d = 1'b0;
        end
    end

    always_comb begin
        data1_d  = data1_q;
        valid1_d = valid1_q;
        cnt1_d   = cnt1_q;
        if (load1) begin
            data1_d  = in_data;
            valid1_d = 1'b1;
            if (cnt1_q != CntMax) begin
                cnt1_d = cnt1_q + CntOne;
            end
        end else if (drain1) begin
            valid1_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data0_q  <= '0;
            data1_q  <= '0;
            valid0_q <= 1'b0;
            valid1_q <= 1'b0;
            cnt0_q   <= '0;
            cnt1_q   <= '0;
        end else begin
            data0_q  <= data0_d;
            data1_q  <= data1_d;
            valid0_q <= valid0_d;
            valid1_q <= valid1_d;
            cnt0_q   <= cnt0_d;
            cnt1_q   <= cnt1_d;
        end
    end

    assign out0_data  = data0_q;
    assign out1_data  = data1_q;
    assign out0_valid = valid0_q;
    assign out1_valid = valid1_q;
    assign count0     = cnt0_q;
    assign count1     = cnt1_q;

endmodule

// File: tb/tb_bus_demux1_2_reg.sv
// Self-checking bench for bus_demux1_2_reg: reference model plus per-port word scoreboards,
// driven by a vector table and a few hand-written multi-cycle sequences.
module tb_bus_demux1_2_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] in_data;
    logic        in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] out0_data, out1_data;
    logic        out0_valid, out1_valid;
    logic        out0_ready, out1_ready;
    logic [15:0] count0, count1;

    logic        sInReady;
    logic [63:0] sOut0Data, sOut1Data;
    logic        sOut0Valid, sOut1Valid;
    logic [3:0]  sCount0, sCount1;

    int checks = 0;
    int errors = 0;

    logic        mValid [2];
    logic [63:0] mData  [2];
    logic [15:0] mCount [2];
    logic [63:0] sbq0 [$];
    logic [63:0] sbq1 [$];

    typedef struct {
        logic        v;
        logic        s;
        logic [63:0] d;
        logic        r0;
        logic        r1;
        logic        expReady;
    } vec_t;

    vec_t tbl [14];

    always #5 clk = ~clk;

    bus_demux1_2_reg dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
        .out0_data(out0_data), .out0_valid(out0_valid), .out0_ready(out0_ready),
        .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
        .count0(count0), .count1(count1)
    );

    bus_demux1_2_reg #(.WIDTH(64), .CNT_WIDTH(4)) dutSmall (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(sInReady),
        .out0_data(sOut0Data), .out0_valid(sOut0Valid), .out0_ready(out0_ready),
        .out1_data(sOut1Data), .out1_valid(sOut1Valid), .out1_ready(out1_ready),
        .count0(sCount0), .count1(sCount1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic resetModel();
        for (int k = 0; k < 2; k++) begin
            mValid[k] = 1'b0;
            mData[k]  = '0;
            mCount[k] = '0;
        end
        sbq0.delete();
        sbq1.delete();
    endtask

    task automatic checkOutput(input logic expReady);
        check("in_ready",   {63'd0, in_ready},   {63'd0, expReady});
        check("out0_valid", {63'd0, out0_valid}, {63'd0, mValid[0]});
        check("out1_valid", {63'd0, out1_valid}, {63'd0, mValid[1]});
        check("out0_data",  out0_data, mData[0]);
        check("out1_data",  out1_data, mData[1]);
        check("count0",     {48'd0, count0}, {48'd0, mCount[0]});
        check("count1",     {48'd0, count1}, {48'd0, mCount[1]});
    endtask

    // One cycle: drive at posedge+1, compare before the next edge, then advance the model.
    task automatic applyStimulus(input logic v, input logic s, input logic [63:0] d,
                                 input logic r0, input logic r1,
                                 input logic useTbl, input logic tblReady);
        logic        expReady;
        logic        acc;
        logic [63:0] w;
        in_valid   = v;
        in_sel     = s;
        in_data    = d;
        out0_ready = r0;
        out1_ready = r1;
        @(negedge clk);
        expReady = s ? (!mValid[1] || r1) : (!mValid[0] || r0);
        checkOutput(expReady);
        if (useTbl) check("tbl_ready", {63'd0, in_ready}, {63'd0, tblReady});
        if (mValid[0] && r0 && sbq0.size() > 0) begin
            w = sbq0.pop_front();
            check("sb_out0", out0_data, w);
        end
        if (mValid[1] && r1 && sbq1.size() > 0) begin
            w = sbq1.pop_front();
            check("sb_out1", out1_data, w);
        end
        acc = v && expReady;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (acc && (s == k[0])) begin
                mValid[k] = 1'b1;
                mData[k]  = d;
                if (mCount[k] != 16'hFFFF) mCount[k] = mCount[k] + 16'd1;
                if (k == 0) sbq0.push_back(d);
                else        sbq1.push_back(d);
            end else if (mValid[k] && (k == 0 ? r0 : r1)) begin
                mValid[k] = 1'b0;
            end
        end
        #1;
    endtask

    initial begin
        for (int i = 0; i < 8; i++)
            tbl[i] = '{v: 1'b1, s: i[0], d: 64'(i), r0: 1'b1, r1: 1'b1, expReady: 1'b1};
        tbl[8]  = '{v: 1'b0, s: 1'b0, d: 64'h0,    r0: 1'b1, r1: 1'b1, expReady: 1'b1};
        tbl[9]  = '{v: 1'b1, s: 1'b0, d: 64'hCA35, r0: 1'b0, r1: 1'b1, expReady: 1'b1};
        tbl[10] = '{v: 1'b1, s: 1'b0, d: 64'h1111, r0: 1'b0, r1: 1'b1, expReady: 1'b0};
        tbl[11] = '{v: 1'b1, s: 1'b0, d: 64'h1111, r0: 1'b0, r1: 1'b1, expReady: 1'b0};
        tbl[12] = '{v: 1'b1, s: 1'b0, d: 64'h1111, r0: 1'b1, r1: 1'b1, expReady: 1'b1};
        tbl[13] = '{v: 1'b0, s: 1'b0, d: 64'h0,    r0: 1'b0, r1: 1'b1, expReady: 1'b0};

        reset = 1'b1;
        in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
        out0_ready = 1'b0; out1_ready = 1'b0;
        resetModel();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Streaming with alternating destinations.
        for (int i = 0; i <= 8; i++)
            applyStimulus(tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].r0, tbl[i].r1, 1'b1, tbl[i].expReady);
        check("stream_count0", {48'd0, count0}, 64'd4);
        check("stream_count1", {48'd0, count1}, 64'd4);

        // Backpressure on port 0.
        for (int i = 9; i <= 13; i++)
            applyStimulus(tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].r0, tbl[i].r1, 1'b1, tbl[i].expReady);
        check("bp_out0_data", out0_data, 64'h1111);
        check("bp_count0", {48'd0, count0}, 64'd6);

        // Cross-port: out0 stalled and full, word for port 1 still goes through.
        applyStimulus(1'b1, 1'b1, 64'hE6F2, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 64'h0,    1'b0, 1'b1, 1'b0, 1'b0);
        check("xp_out1_data", out1_data, 64'hE6F2);
        check("xp_out0_data", out0_data, 64'h1111);
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 1'b0);

        // Idle with readies toggling.
        for (int i = 0; i < 10; i++)
            applyStimulus(1'b0, 1'(i), 64'h0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);

        // Asynchronous reset mid-cycle with out1 holding a word.
        applyStimulus(1'b1, 1'b1, 64'hDEAD, 1'b1, 1'b0, 1'b0, 1'b0);
        check("pre_rst_out1", out1_data, 64'hDEAD);
        #2 reset = 1'b1;
        #1;
        resetModel();
        checkOutput(1'b1);
        check("rst_small_count1", {60'd0, sCount1}, 64'd0);
        in_valid = 1'b1; in_sel = 1'b1; in_data = 64'hBEEF; out1_ready = 1'b0;
        @(posedge clk);
        #1;
        checkOutput(1'b1);
        reset = 1'b0;

        // Counter saturation on the 4-bit instance.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 1'b1, 64'(i + 100), 1'b1, 1'b1, 1'b0, 1'b0);
            if (i == 14) check("sat_small_at15", {60'd0, sCount1}, 64'd15);
        end
        check("sat_small_count1", {60'd0, sCount1}, 64'd15);
        check("sat_small_count0", {60'd0, sCount0}, 64'd0);
        check("sat_wide_count1", {48'd0, count1}, 64'd20);
        check("sat_small_data1", sOut1Data, 64'd119);
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
